// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit is produced per cycle in CALC. Divide-by-zero and signed
// overflow take a single-cycle path straight to DONE.
// Handshake: start is accepted only in IDLE with kill low; done is a one-cycle
// pulse with result valid in that cycle; busy is high while in CALC; kill aborts
// CALC/DONE at the next edge and beats start in IDLE.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       funct,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state_q;
    state_t state_d;

    // Datapath registers
    logic [WIDTH-1:0] dvd_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [CNT_W-1:0] cnt_q;
    logic             rem_sel_q;  // 1: return remainder, 0: quotient
    logic             q_neg_q;
    logic             r_neg_q;
    logic [WIDTH-1:0] result_q;

    // Request decode in IDLE
    logic             accept;
    logic             signed_op;
    logic             is_rem;
    logic             div_zero;
    logic             sovf;
    logic             fast_path;
    logic [WIDTH-1:0] fast_res;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;

    // One restoring step
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] calc_res;
    logic             last_iter;

    // Decode the incoming request and precompute the fast-path answer
    always_comb begin
        signed_op = ~funct[0];
        is_rem    = funct[1];
        accept    = (state_q == S_IDLE) && start && !kill;
        div_zero  = (op2 == '0);
        sovf      = signed_op && (op1 == MIN_NEG) && (op2 == ALL_ONE);
        fast_path = div_zero || sovf;
        if (div_zero) begin
            fast_res = is_rem ? op1 : ALL_ONE;
        end else begin
            fast_res = is_rem ? '0 : MIN_NEG;
        end
        op1_abs = (signed_op && op1[WIDTH-1]) ? (~op1 + ONE) : op1;
        op2_abs = (signed_op && op2[WIDTH-1]) ? (~op2 + ONE) : op2;
    end

    // Trial subtraction for the current iteration and sign-corrected final value.
    // The partial remainder is always below the divisor, so a WIDTH+1-bit
    // difference has its top bit set exactly when the subtraction would go negative.
    always_comb begin
        shifted   = {rem_q, dvd_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvs_q};
        trial_ok  = ~diff[WIDTH];
        rem_next  = trial_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next  = {dvd_q[WIDTH-2:0], trial_ok};
        quo_fix   = q_neg_q ? (~quo_next + ONE) : quo_next;
        rem_fix   = r_neg_q ? (~rem_next + ONE) : rem_next;
        calc_res  = rem_sel_q ? rem_fix : quo_fix;
        last_iter = (state_q == S_CALC) && (cnt_q == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = fast_path ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; kill in the DONE cycle swallows the pulse
    always_comb begin
        busy      = (state_q == S_CALC);
        done      = (state_q == S_DONE) && !kill;
        dbg_state = state_q;
        result    = result_q;
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            if (accept) begin
                rem_sel_q <= is_rem;
                if (fast_path) begin
                    result_q <= fast_res;
                end else begin
                    dvd_q   <= op1_abs;
                    dvs_q   <= op2_abs;
                    rem_q   <= '0;
                    cnt_q   <= CNT_MAX;
                    q_neg_q <= signed_op && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                    r_neg_q <= signed_op && op1[WIDTH-1];
                end
            end else if ((state_q == S_CALC) && !kill) begin
                dvd_q <= quo_next;
                rem_q <= rem_next;
                cnt_q <= cnt_q - CNT_ONE;
                if (last_iter) begin
                    result_q <= calc_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an
// arithmetic reference model of DIV/DIVU/REM/REMU.
module tb_div_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic         clk;
    logic         rst;
    logic         start;
    logic         kill;
    logic [1:0]   funct;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [1:0]   dbg_state;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .kill      (kill),
        .funct     (funct),
        .op1       (op1),
        .op2       (op2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Comparison and reporting
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference model: plain integer division with the ISA's corner rules
    function automatic logic [W-1:0] ref_div(input logic [1:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa;
        longint sb;
        if (b == '0) return f[1] ? a : '1;
        if (!f[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return f[1] ? W'(sa % sb) : W'(sa / sb);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    // Driver: call just after a rising edge; start goes high for that cycle (cycle 0)
    task automatic run_op(input string tag, input logic [1:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic         fast;
        logic         got;
        int           cyc;
        int           busy_n;
        logic [W-1:0] want;
        fast = (b == '0) || (!f[0] && a == MIN_NEG && b == '1);
        exp_q.push_back(ref_div(f, a, b));
        funct = f;
        op1   = a;
        op2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = 2'($urandom);
        op1   = $urandom;
        op2   = $urandom;
        cyc    = 1;
        busy_n = 0;
        got    = 1'b0;
        while (!got && cyc <= 60) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) got = 1'b1;
            else begin
                cyc++;
                @(posedge clk);
            end
        end
        want = exp_q.pop_front();
        check({tag, "_lat"}, W'(cyc), W'(fast ? 1 : 33));
        check({tag, "_busy"}, W'(busy_n), W'(fast ? 0 : 32));
        check({tag, "_res"}, result, want);
        last_res = want;
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, W'(done), '0);
    endtask

    initial begin
        logic [1:0]   rf;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         seen_done;

        rst   = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        funct = 2'b00;
        op1   = '0;
        op2   = '0;
        last_res = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_result", result, '0);
        check("rst_state", W'(dbg_state), '0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
        run_op("div_by0", 2'b00, 32'd5, 32'd0);
        run_op("remu_by0", 2'b11, 32'd5, 32'd0);
        run_op("div_ovf", 2'b00, MIN_NEG, 32'hFFFF_FFFF);
        run_op("rem_ovf", 2'b10, MIN_NEG, 32'hFFFF_FFFF);
        run_op("divu_ovf", 2'b01, MIN_NEG, 32'hFFFF_FFFF);

        // Kill in cycle 10 of a running op, then restart in cycle 11
        funct = 2'b01; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            seen_done |= done;
            @(posedge clk);
        end
        #1;
        kill = 1'b1;
        @(negedge clk);
        seen_done |= done;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", W'(busy), '0);
        check("kill_state", W'(dbg_state), '0);
        check("kill_nodone", W'(seen_done | done), '0);
        check("kill_result", result, last_res);
        run_op("after_kill", 2'b01, 32'd9, 32'd3);

        // Kill together with start in IDLE drops the request
        funct = 2'b01; op1 = 32'd50; op2 = 32'd5; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        check("kill_idle_busy", W'(busy), '0);
        check("kill_idle_state", W'(dbg_state), '0);
        @(posedge clk);
        #1;
        check("kill_idle_done", W'(done), '0);
        check("kill_idle_result", result, last_res);

        // Kill in the DONE cycle suppresses the pulse
        funct = 2'b00; op1 = 32'd5; op2 = 32'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b1;
        @(negedge clk);
        check("kill_done_pulse", W'(done), '0);
        check("kill_done_result", result, 32'hFFFF_FFFF);
        last_res = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_done_state", W'(dbg_state), '0);

        // Start during the DONE cycle is ignored
        funct = 2'b11; op1 = 32'd5; op2 = 32'd0; start = 1'b1;
        @(posedge clk);
        #1;
        funct = 2'b01; op1 = 32'd100; op2 = 32'd7;
        @(negedge clk);
        check("done_start_pulse", W'(done), 32'd1);
        check("done_start_result", result, 32'd5);
        last_res = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_start_busy", W'(busy), '0);
        check("done_start_state", W'(dbg_state), '0);
        @(posedge clk);
        #1;

        // Asynchronous reset in cycle 15 of a running op
        funct = 2'b01; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        start = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", W'(busy), '0);
        check("arst_done", W'(done), '0);
        check("arst_result", result, '0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_busy", W'(busy), '0);
        check("arst_hold_state", W'(dbg_state), '0);
        start = 1'b0;
        #1;
        rst = 1'b1;
        last_res = '0;
        @(posedge clk);
        #1;
        check("arst_release_busy", W'(busy), '0);
        run_op("post_rst", 2'b01, 32'hFFFF_FFFF, 32'd1);

        // Randomized operations with corner-biased operands
        for (int n = 0; n < 40; n++) begin
            rf = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin ra = $urandom; rb = '0; end
                1: begin ra = MIN_NEG; rb = '1; end
                2: begin ra = W'($urandom_range(0, 1000)); rb = W'($urandom_range(1, 20)); end
                3: begin ra = $urandom; rb = -W'($urandom_range(1, 20)); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            run_op("rand", rf, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
